prog_updown_counter: RTL

- Parametrised loadable up/down counter; next generation of the team's 4-bit latch/decrement/zero counter.
- Adds: generic width, an increment path, saturate-or-wrap mode, auto-reload from a stored value, terminal-count pulse, sticky error flag.
- Used as a timer/event-count primitive inside datapath control blocks.

---
 rtl/prog_updown_counter.sv | 93 +++++++++
 1 files changed

// File: rtl/prog_updown_counter.sv
// Loadable up/down counter with saturate-or-wrap bounds, auto-reload on
// underflow, registered zero/max flags, terminal-count pulse and sticky error.
module prog_updown_counter #(
  parameter int WIDTH     = 4,
  parameter int RESET_VAL = 0,
  parameter bit SATURATE  = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] IN,
  input  logic             latch,
  input  logic             dec,
  input  logic             inc,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             zero,
  output logic             max,
  output logic             tc_pulse,
  output logic             err
);

  localparam logic [WIDTH-1:0] MAXV = '1;
  localparam logic [WIDTH-1:0] RSTV = WIDTH'(RESET_VAL);
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  logic [WIDTH-1:0] r_cnt, r_rld;
  logic             r_zero, r_max, r_tc, r_err;

  logic [WIDTH-1:0] w_cnt_nxt, w_rld_nxt;
  logic             w_tc_nxt, w_err_nxt;

  always_comb begin
    w_cnt_nxt = r_cnt;
    w_rld_nxt = r_rld;
    w_tc_nxt  = 1'b0;
    w_err_nxt = r_err;
    if (latch) begin
      w_cnt_nxt = IN;
      w_rld_nxt = IN;
      w_err_nxt = 1'b0;
    end else if (inc && dec) begin
      w_cnt_nxt = r_cnt;
    end else if (dec) begin
      if (r_cnt == ONE) begin
        w_cnt_nxt = '0;
        w_tc_nxt  = 1'b1;
      end else if (r_cnt == '0) begin
        // Reload is a normal event, not an underflow.
        if (auto_reload) begin
          w_cnt_nxt = r_rld;
        end else begin
          w_cnt_nxt = SATURATE ? '0 : MAXV;
          w_err_nxt = 1'b1;
        end
      end else begin
        w_cnt_nxt = r_cnt - ONE;
      end
    end else if (inc) begin
      if (r_cnt == MAXV) begin
        w_cnt_nxt = SATURATE ? MAXV : '0;
        w_err_nxt = 1'b1;
      end else begin
        w_cnt_nxt = r_cnt + ONE;
      end
    end
  end

  // Flags are computed from the next count so they line up with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= RSTV;
      r_rld  <= RSTV;
      r_zero <= (RSTV == '0);
      r_max  <= (RSTV == MAXV);
      r_tc   <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_rld  <= w_rld_nxt;
      r_zero <= (w_cnt_nxt == '0);
      r_max  <= (w_cnt_nxt == MAXV);
      r_tc   <= w_tc_nxt;
      r_err  <= w_err_nxt;
    end
  end

  assign count    = r_cnt;
  assign zero     = r_zero;
  assign max      = r_max;
  assign tc_pulse = r_tc;
  assign err      = r_err;

endmodule
